// File: rtl/ysyx_25030093_exu_pkg.sv
// Shared definitions for the EXU ALU/MDU slice: op codes, FSM state type and M-op decode helpers.
package ysyx_25030093_exu_pkg;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_SLL    = 5'h02;
    localparam logic [4:0] OP_SLT    = 5'h03;
    localparam logic [4:0] OP_SLTU   = 5'h04;
    localparam logic [4:0] OP_XOR    = 5'h05;
    localparam logic [4:0] OP_SRL    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_OR     = 5'h08;
    localparam logic [4:0] OP_AND    = 5'h09;
    localparam logic [4:0] OP_BEQ    = 5'h0A;
    localparam logic [4:0] OP_BNE    = 5'h0B;
    localparam logic [4:0] OP_BLT    = 5'h0C;
    localparam logic [4:0] OP_BGE    = 5'h0D;
    localparam logic [4:0] OP_BLTU   = 5'h0E;
    localparam logic [4:0] OP_BGEU   = 5'h0F;
    localparam logic [4:0] OP_CSRRW  = 5'h10;
    localparam logic [4:0] OP_CSRRS  = 5'h11;
    localparam logic [4:0] OP_CSRRC  = 5'h12;
    localparam logic [4:0] OP_LUI    = 5'h13;

    localparam logic [4:0] OP_MUL    = 5'h18;
    localparam logic [4:0] OP_MULH   = 5'h19;
    localparam logic [4:0] OP_MULHSU = 5'h1A;
    localparam logic [4:0] OP_MULHU  = 5'h1B;
    localparam logic [4:0] OP_DIV    = 5'h1C;
    localparam logic [4:0] OP_DIVU   = 5'h1D;
    localparam logic [4:0] OP_REM    = 5'h1E;
    localparam logic [4:0] OP_REMU   = 5'h1F;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } exu_state_e;

    function automatic logic is_m_op(input logic [4:0] op);
        return op >= OP_MUL;
    endfunction

    function automatic logic mdu_is_div(input logic [4:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // Upper product half for MULH*, remainder for REM*.
    function automatic logic mdu_upper(input logic [4:0] op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    endfunction

    function automatic logic mdu_signed_a(input logic [4:0] op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic mdu_signed_b(input logic [4:0] op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/ysyx_25030093_alu.sv
// Combinational integer ALU: arithmetic/logic, branch compare and CSR write-value generation.
module ysyx_25030093_alu
    import ysyx_25030093_exu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] csr,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] csr_wdata,
    output logic            branch,
    output logic            illegal
);

    localparam int unsigned SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic            lt_s;
    logic            lt_u;

    assign shamt = b[SH_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        result    = '0;
        csr_wdata = '0;
        branch    = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_SLL:   result = a << shamt;
            OP_SLT:   result = XLEN'(lt_s);
            OP_SLTU:  result = XLEN'(lt_u);
            OP_XOR:   result = a ^ b;
            OP_SRL:   result = a >> shamt;
            OP_SRA:   result = $signed(a) >>> shamt;
            OP_OR:    result = a | b;
            OP_AND:   result = a & b;
            OP_BEQ:   branch = a == b;
            OP_BNE:   branch = a != b;
            OP_BLT:   branch = lt_s;
            OP_BGE:   branch = ~lt_s;
            OP_BLTU:  branch = lt_u;
            OP_BGEU:  branch = ~lt_u;
            OP_CSRRW: begin
                result    = csr;
                csr_wdata = a;
            end
            OP_CSRRS: begin
                result    = csr;
                csr_wdata = csr | a;
            end
            OP_CSRRC: begin
                result    = csr;
                csr_wdata = csr & ~a;
            end
            OP_LUI:   result = b;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_25030093_mdu.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, XLEN cycles per op.
// Present only when YSYX_25030093_EXU_MDU_EN is defined; otherwise an inert shell.
module ysyx_25030093_mdu
    import ysyx_25030093_exu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            done,
    output logic [XLEN-1:0] result
);

`ifdef YSYX_25030093_EXU_MDU_EN
    localparam int unsigned CNT_W = $clog2(XLEN);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  hi_q, lo_q, mcand_q, src1_q;
    logic             is_div_q, upper_q, neg_main_q, neg_rem_q, div_zero_q;

    logic             sign_a, sign_b;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic [XLEN:0]    mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [XLEN-1:0]  hi_n, lo_n, quo, rem;
    logic [2*XLEN-1:0] prod;

    assign sign_a = mdu_signed_a(op) && src1[XLEN-1];
    assign sign_b = mdu_signed_b(op) && src2[XLEN-1];
    assign mag_a  = sign_a ? -src1 : src1;
    assign mag_b  = sign_b ? -src2 : src2;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign div_ge    = ~div_diff[XLEN];

    // hi holds the running product high half / partial remainder; lo the multiplier / quotient.
    always_comb begin
        if (is_div_q) begin
            hi_n = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = neg_main_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        quo  = neg_main_q ? -lo_n : lo_n;
        rem  = neg_rem_q ? -hi_n : hi_n;
        if (!is_div_q) begin
            result = upper_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end else if (div_zero_q) begin
            result = upper_q ? src1_q : '1;
        end else begin
            result = upper_q ? rem : quo;
        end
    end

    assign done = busy_q && (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            src1_q     <= '0;
            is_div_q   <= 1'b0;
            upper_q    <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (kill) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= mag_a;
            mcand_q    <= mag_b;
            src1_q     <= src1;
            is_div_q   <= mdu_is_div(op);
            upper_q    <= mdu_upper(op);
            neg_main_q <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            div_zero_q <= src2 == '0;
        end else if (busy_q) begin
            hi_q   <= hi_n;
            lo_q   <= lo_n;
            cnt_q  <= done ? '0 : cnt_q + CNT_W'(1);
            busy_q <= ~done;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{clk, rst, start, kill, op, src1, src2};
    assign done          = 1'b0;
    assign result        = '0;
`endif

endmodule

// File: rtl/ysyx_25030093_exu_mdu.sv
// EXU front end: one-cycle ALU ops and iterative M ops behind a valid/ready handshake.
// M ops execute only when YSYX_25030093_EXU_MDU_EN is defined; otherwise they report illegal.
module ysyx_25030093_exu_mdu
    import ysyx_25030093_exu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OP_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] alu_data1,
    input  logic [XLEN-1:0] alu_data2,
    input  logic [XLEN-1:0] csr_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] csr_wdata,
    output logic            B_single,
    output logic            illegal
);

    exu_state_e      state_q, state_d;
    logic [XLEN-1:0] rd_q, rd_d, csrw_q, csrw_d;
    logic            b_q, b_d, ill_q, ill_d;

    logic [4:0]      op5;
    logic            op_over;
    logic            m_op;
    logic            mdu_start;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;
    logic [XLEN-1:0] alu_result, alu_csrw;
    logic            alu_branch, alu_illegal;

    // Codes beyond the 5-bit op space (wide OP_W builds) are never legal.
    assign op5     = op[4:0];
    assign op_over = (op >> 5) != '0;
    assign m_op    = ~op_over && is_m_op(op5);

    ysyx_25030093_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .op       (op5),
        .a        (alu_data1),
        .b        (alu_data2),
        .csr      (csr_data),
        .result   (alu_result),
        .csr_wdata(alu_csrw),
        .branch   (alu_branch),
        .illegal  (alu_illegal)
    );

    ysyx_25030093_mdu #(
        .XLEN(XLEN)
    ) u_mdu (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_start),
        .kill  (flush),
        .op    (op5),
        .src1  (alu_data1),
        .src2  (alu_data2),
        .done  (mdu_done),
        .result(mdu_result)
    );

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        csrw_d    = csrw_q;
        b_d       = b_q;
        ill_d     = ill_q;
        mdu_start = 1'b0;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (m_op) begin
`ifdef YSYX_25030093_EXU_MDU_EN
                            state_d   = StCalc;
                            mdu_start = 1'b1;
`else
                            state_d = StDone;
                            rd_d    = '0;
                            csrw_d  = '0;
                            b_d     = 1'b0;
                            ill_d   = 1'b1;
`endif
                        end else begin
                            state_d = StDone;
                            rd_d    = alu_result;
                            csrw_d  = alu_csrw;
                            b_d     = alu_branch;
                            ill_d   = alu_illegal | op_over;
                        end
                    end
                end
                StCalc: begin
                    if (mdu_done) begin
                        state_d = StDone;
                        rd_d    = mdu_result;
                        csrw_d  = '0;
                        b_d     = 1'b0;
                        ill_d   = 1'b0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rd_q    <= '0;
            csrw_q  <= '0;
            b_q     <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            csrw_q  <= csrw_d;
            b_q     <= b_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready  = state_q == StIdle;
    assign out_valid = state_q == StDone;
    assign rd_data   = rd_q;
    assign csr_wdata = csrw_q;
    assign B_single  = b_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_ysyx_25030093_exu_mdu.sv
// Scoreboard bench for ysyx_25030093_exu_mdu: directed vectors, queue of expected results,
// independent monitor comparing every cycle the DUT presents out_valid.
module tb_ysyx_25030093_exu_mdu;
    import ysyx_25030093_exu_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 5;
`ifdef YSYX_25030093_EXU_MDU_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] alu_data1, alu_data2, csr_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd_data, csr_wdata;
    logic            b_single;
    logic            illegal;

    ysyx_25030093_exu_mdu #(
        .XLEN(XLEN),
        .OP_W(OP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .alu_data1(alu_data1),
        .alu_data2(alu_data2),
        .csr_data (csr_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .rd_data  (rd_data),
        .csr_wdata(csr_wdata),
        .B_single (b_single),
        .illegal  (illegal)
    );

    typedef struct {
        logic [XLEN-1:0] rd;
        logic [XLEN-1:0] csrw;
        logic            b;
        logic            ill;
        int unsigned     at;
        string           name;
    } exp_t;

    exp_t        sb_q[$];
    bit          seen;
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare on every cycle out_valid is shown; retire the entry on handshake.
    always @(negedge clk) begin
        if (!rst || !out_valid) begin
            seen <= 1'b0;
        end else if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got out_valid 1 rd_data 0x%0h, required 0", rd_data);
        end else begin
            if (!seen) chk({sb_q[0].name, "_latency"}, 64'(cyc), 64'(sb_q[0].at));
            seen <= 1'b1;
            chk({sb_q[0].name, "_rd"}, 64'(rd_data), 64'(sb_q[0].rd));
            chk({sb_q[0].name, "_csrw"}, 64'(csr_wdata), 64'(sb_q[0].csrw));
            chk({sb_q[0].name, "_b"}, 64'(b_single), 64'(sb_q[0].b));
            chk({sb_q[0].name, "_illegal"}, 64'(illegal), 64'(sb_q[0].ill));
            if (out_ready) begin
                void'(sb_q.pop_front());
                seen <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] c, input bit push, input logic [XLEN-1:0] erd,
                         input logic [XLEN-1:0] ecsr, input logic eb, input logic eill,
                         input int unsigned lat, input string name);
        exp_t e;
        int   g = 0;
        while (!in_ready && g < 300) begin
            tick();
            g++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got in_ready 0, required 1", name);
            return;
        end
        op        = o;
        alu_data1 = a;
        alu_data2 = b;
        csr_data  = c;
        in_valid  = 1'b1;
        if (push) begin
            e.rd = erd; e.csrw = ecsr; e.b = eb; e.ill = eill; e.at = cyc + lat; e.name = name;
            sb_q.push_back(e);
        end
        tick();
        in_valid  = 1'b0;
        alu_data1 = $urandom;
        alu_data2 = $urandom;
        csr_data  = $urandom;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (sb_q.size() != 0 && g < 300) begin
            tick();
            g++;
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] c, input logic [XLEN-1:0] erd,
                       input logic [XLEN-1:0] ecsr, input logic eb, input logic eill,
                       input string name);
        drive(o, a, b, c, 1'b1, erd, ecsr, eb, eill, 1, name);
        drain(name);
    endtask

    // M op: full result after XLEN+1 cycles when enabled, else one-cycle illegal with rd 0.
    task automatic m_run(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] erd, input string name);
        if (M_EN) drive(o, a, b, '0, 1'b1, erd, '0, 1'b0, 1'b0, XLEN + 1, name);
        else      drive(o, a, b, '0, 1'b1, '0, '0, 1'b0, 1'b1, 1, name);
        drain(name);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; flush = 1'b0; out_ready = 1'b1;
        alu_data1 = '0; alu_data2 = '0; csr_data = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_rd", 64'(rd_data), 64'd0);
        chk("reset_flags", 64'({csr_wdata, b_single, illegal}), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ADD with result held while out_ready stays low
        out_ready = 1'b0;
        drive(OP_ADD, 32'd3, 32'd4, '0, 1'b1, 32'd7, '0, 1'b0, 1'b0, 1, "add_hold");
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        drain("add_hold");

        run(OP_SUB,   32'd5,        32'd7,  '0,      32'hFFFF_FFFE, '0,    1'b0, 1'b0, "sub");
        run(OP_SLT,   32'hFFFF_FFFF, 32'd1, '0,      32'd1,         '0,    1'b0, 1'b0, "slt");
        run(OP_SLTU,  32'hFFFF_FFFF, 32'd1, '0,      32'd0,         '0,    1'b0, 1'b0, "sltu");
        run(OP_SRA,   32'h8000_0000, 32'd4, '0,      32'hF800_0000, '0,    1'b0, 1'b0, "sra");
        run(OP_SLL,   32'd1,        32'h21, '0,      32'd2,         '0,    1'b0, 1'b0, "sll");
        run(OP_BEQ,   32'd5,        32'd5,  '0,      '0,            '0,    1'b1, 1'b0, "beq");
        run(OP_BLT,   32'hFFFF_FFFF, 32'd0, '0,      '0,            '0,    1'b1, 1'b0, "blt");
        run(OP_BLTU,  32'hFFFF_FFFF, 32'd0, '0,      '0,            '0,    1'b0, 1'b0, "bltu");
        run(OP_CSRRS, 32'h0F,       32'd0,  32'hF0,  32'hF0,        32'hFF, 1'b0, 1'b0, "csrrs");
        run(OP_CSRRC, 32'h0F,       32'd0,  32'hFF,  32'hFF,        32'hF0, 1'b0, 1'b0, "csrrc");
        run(5'h14,    32'd1,        32'd2,  '0,      '0,            '0,    1'b0, 1'b1, "unsupported");

        m_run(OP_MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, "mul");
        m_run(OP_MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, "mulhu");
        m_run(OP_MULH,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulh");
        m_run(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu");
        m_run(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        m_run(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
        m_run(OP_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, "divu_zero");
        m_run(OP_REMU,   32'd7,         32'd0,         32'd7,         "remu_zero");
        m_run(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_neg");
        m_run(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_neg");
        m_run(OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_zero");

        // flush beats a same-cycle accept
        op = OP_ADD; alu_data1 = 32'd1; alu_data2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_out_valid", 64'(out_valid), 64'd0);
        chk("flush_accept_in_ready", 64'(in_ready), 64'd1);

        // flush while a result is waiting in DONE
        out_ready = 1'b0;
        drive(OP_ADD, 32'd10, 32'd20, '0, 1'b1, 32'd30, '0, 1'b0, 1'b0, 1, "flush_done");
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_done_out_valid", 64'(out_valid), 64'd0);
        chk("flush_done_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        out_ready = 1'b1;

        if (M_EN) begin
            drive(OP_DIV, 32'd100, 32'd7, '0, 1'b0, '0, '0, 1'b0, 1'b0, 0, "div_flush");
            repeat (9) tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("flush_calc_in_ready", 64'(in_ready), 64'd1);
            chk("flush_calc_out_valid", 64'(out_valid), 64'd0);
            repeat (XLEN + 4) tick();
        end
        run(OP_ADD, 32'd3, 32'd4, '0, 32'd7, '0, 1'b0, 1'b0, "add_after_flush");

        // reset mid-operation clears outputs without a clock edge
        if (M_EN) begin
            drive(OP_DIV, 32'd100, 32'd7, '0, 1'b0, '0, '0, 1'b0, 1'b0, 0, "div_rst");
            repeat (5) tick();
        end else begin
            out_ready = 1'b0;
            drive(OP_ADD, 32'd3, 32'd4, '0, 1'b1, 32'd7, '0, 1'b0, 1'b0, 1, "add_rst");
            tick();
        end
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_rd", 64'(rd_data), 64'd0);
        chk("rst_mid_flags", 64'({csr_wdata, b_single, illegal}), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);
        m_run(OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, "divu_after_rst");
        run(OP_ADD, 32'd3, 32'd4, '0, 32'd7, '0, 1'b0, 1'b0, "add_after_rst");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
